alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Issue-side controller for the 8-bit ALU. Accepts 9-bit instructions over valid/ready,
//  decodes them into the ALU's 5-bit operation code, reads operands from a local 8x8 register
//  file, drives the ALU, and writes the result back. Sits between fetch and the alu instance.
// PARAMETERS
//  NREGS   8   register count (power of 2; instr rd/rs fields are $clog2(NREGS) = 3 bits)
//  DW      8   data width; must match the ALU
// PORTS
//  clk          in   1   single clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  instr_valid  in   1   instruction word present
//  instr_ready  out  1   controller can accept (IDLE and no host write this cycle)
//  instr        in   9   [8:6] op, [5:3] rd, [2:0] rs ; rd <= rd OP rs
//  host_we      in   1   host register write (init/debug)
//  host_addr    in   3   host write/read address
//  host_wdata   in   8   host write data
//  host_rdata   out  8   combinational read of reg[host_addr]
//  alu_op       out  5   to ALU operation input (registered)
//  alu_a        out  8   to ALU in1 (registered, = reg[rd])
//  alu_b        out  8   to ALU in2 (registered, = reg[rs])
//  alu_result   in   8   from ALU out
//  done         out  1   one-cycle pulse on writeback
// BEHAVIOUR
//  Reset: state=IDLE; all regs, alu_op, alu_a, alu_b = 0; done=0; instr_ready=1 once released.
//  Op map: 000 AND->00000, 001 OR->00001, 010 NOT->00010, 011 XOR->00011, 100 ADD->00100,
//   101 SUB->00101, 110 LSL->10000, 111 LSR->10001. All eight codes legal; 11111111 never expected.
//  FSM IDLE->DECODE->EXEC->WB->IDLE:
//   IDLE:   instr_ready=1 iff !host_we; on valid&ready latch rd/rs/op -> DECODE.
//   DECODE: register alu_op, alu_a=reg[rd], alu_b=reg[rs] -> EXEC.
//   EXEC:   ALU settles; capture alu_result into result reg -> WB.
//   WB:     reg[rd] <= result; done=1 this cycle -> IDLE.
//  Latency: accept at edge N, done high during cycle N+3, register updated at edge N+3.
//  Throughput: one instruction per 4 cycles; instr_ready=0 in DECODE/EXEC/WB.
//  Host write: honoured any state except WB-to-same-address; in WB, if host_addr==rd,
//   writeback wins. host_we in IDLE blocks acceptance that cycle (host wins).
//  rd==rs legal: both operands read from same register before writeback.
//  Widths: no carry/overflow kept; 8-bit wrap (0xFF+0x01 -> 0x00, 0x00-0x01 -> 0xFF).
//   Shift amount is full 8-bit alu_b; amounts >=8 yield 0. NOT result is ALU-defined (0x00/0x01).
//  Reset mid-operation: abort immediately, registers cleared, no done pulse, back to IDLE.
//  alu_op/alu_a/alu_b hold last values outside DECODE (no toggling while idle).
// CONFIGURATION
//  ALU_ISSUE_FLAGS_EN defined: adds outputs flag_z (1) and flag_n (1), reset 0, updated
//   in WB from written value (z = value==0, n = value[7]); hold otherwise; host writes
//   do not affect flags.
//  Undefined: ports absent, no flag logic.
// STRUCTURE
//  Package alu_issue_pkg: state_t enum {IDLE,DECODE,EXEC,WB}; instr_t packed struct
//   {op[2:0], rd[2:0], rs[2:0]}; localparam ALU opcode constants (ALU_AND..ALU_LSR);
//   function op_to_alu(op[2:0]) -> [4:0].
//  Sub-module alu_issue_regfile: 8x8, two async read ports (rd,rs), one host read port,
//   one write port with WB-over-host priority mux; async reset to zero.
//  alu itself instantiated by the bench/top, not inside this block.
// TESTING (bench instantiates alu_issue_ctrl + alu)
//  Host write r1=0x05, r2=0x03; instr ADD r1,r2 (9'b100_001_010) -> done at N+3, r1=0x08.
//  r3=0xFF, r4=0x01; ADD r3,r4 -> r3=0x00 (wrap); flag_z=1, flag_n=0 with FLAGS_EN.
//  r5=0x01, r6=0x07; LSL r5,r6 -> r5=0x80, flag_n=1; then LSR r5,r6 -> r5=0x01.
//  instr_valid held with host_we=1 in IDLE -> instr_ready=0, no accept until host_we drops.
//  Back-to-back valid instructions -> accepts spaced exactly 4 cycles; SUB r0,r0 -> r0=0x00.
//  Assert rst_n=0 during EXEC -> no done, all regs 0, instr_ready=1 after release.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared types and opcode mapping for the ALU issue controller.
// Optional feature macro: ALU_ISSUE_FLAGS_EN (zero/negative flags on writeback).
package alu_issue_pkg;

  localparam int unsigned RAW = 3;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    EXEC,
    WB
  } state_t;

  typedef struct packed {
    logic [2:0]     op;
    logic [RAW-1:0] rd;
    logic [RAW-1:0] rs;
  } instr_t;

  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_NOT = 5'b00010;
  localparam logic [4:0] ALU_XOR = 5'b00011;
  localparam logic [4:0] ALU_ADD = 5'b00100;
  localparam logic [4:0] ALU_SUB = 5'b00101;
  localparam logic [4:0] ALU_LSL = 5'b10000;
  localparam logic [4:0] ALU_LSR = 5'b10001;

  function automatic logic [4:0] op_to_alu(input logic [2:0] op);
    logic [4:0] code;
    case (op)
      3'b000:  code = ALU_AND;
      3'b001:  code = ALU_OR;
      3'b010:  code = ALU_NOT;
      3'b011:  code = ALU_XOR;
      3'b100:  code = ALU_ADD;
      3'b101:  code = ALU_SUB;
      3'b110:  code = ALU_LSL;
      default: code = ALU_LSR;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Instruction handshake between fetch (master) and the issue controller (slave).
// Optional feature macro of this block: ALU_ISSUE_FLAGS_EN (not used here).
interface alu_issue_if;
  import alu_issue_pkg::*;

  logic   instr_valid;
  logic   instr_ready;
  instr_t instr;

  modport master (output instr_valid, output instr, input instr_ready);
  modport slave  (input instr_valid, input instr, output instr_ready);

endinterface

// File: rtl/alu_issue_regfile.sv
// Register file: two async operand reads, one host read, per-entry writeback-over-host write.
// Optional feature macro of this block: ALU_ISSUE_FLAGS_EN (not used here).
module alu_issue_regfile #(
  parameter  int unsigned NREGS = 8,
  parameter  int unsigned DW    = 8,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rd_addr,
  input  logic [AW-1:0] rs_addr,
  output logic [DW-1:0] rd_data,
  output logic [DW-1:0] rs_data,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic [DW-1:0] host_rdata,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data
);

  logic [DW-1:0] regs [NREGS];

  assign rd_data    = regs[rd_addr];
  assign rs_data    = regs[rs_addr];
  assign host_rdata = regs[host_addr];

  // Host and writeback may both land in one cycle; only a same-entry clash is arbitrated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (wb_we && wb_addr == AW'(i))          regs[i] <= wb_data;
        else if (host_we && host_addr == AW'(i)) regs[i] <= host_wdata;
      end
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts instructions, reads operands, drives the external ALU, writes back.
// Optional feature macro: ALU_ISSUE_FLAGS_EN adds flag_z/flag_n updated on writeback.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter  int unsigned NREGS = 8,
  parameter  int unsigned DW    = 8,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_issue_if.slave    instr_if,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic [DW-1:0] host_rdata,
  output logic [4:0]    alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_result,
  output logic          done
`ifdef ALU_ISSUE_FLAGS_EN
  ,
  output logic          flag_z,
  output logic          flag_n
`endif
);

  state_t        state, state_nxt;
  instr_t        cur;
  logic [DW-1:0] result_q;
  logic [DW-1:0] rd_data, rs_data;
  logic          ready, accept, wb_we;

  assign instr_if.instr_ready = ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A host write in IDLE takes the cycle, so acceptance waits for it.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    accept    = 1'b0;
    wb_we     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready  = !host_we;
        accept = instr_if.instr_valid && !host_we;
        if (accept) state_nxt = DECODE;
      end
      DECODE: state_nxt = EXEC;
      EXEC:   state_nxt = WB;
      WB: begin
        wb_we     = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= '0;
      result_q <= '0;
      alu_op   <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
    end else begin
      if (accept) cur <= instr_if.instr;
      if (state == DECODE) begin
        alu_op <= op_to_alu(cur.op);
        alu_a  <= rd_data;
        alu_b  <= rs_data;
      end
      if (state == EXEC) result_q <= alu_result;
    end
  end

`ifdef ALU_ISSUE_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (wb_we) begin
      flag_z <= (result_q == '0);
      flag_n <= result_q[DW-1];
    end
  end
`endif

  alu_issue_regfile #(
    .NREGS (NREGS),
    .DW    (DW)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr    (cur.rd),
    .rs_addr    (cur.rs),
    .rd_data    (rd_data),
    .rs_data    (rs_data),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .wb_we      (wb_we),
    .wb_addr    (cur.rd),
    .wb_data    (result_q)
  );

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural 8-bit ALU attached.
// Flag checks compile in when ALU_ISSUE_FLAGS_EN is defined.
module tb_alu_issue_ctrl;
  import alu_issue_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       host_we;
  logic [2:0] host_addr;
  logic [7:0] host_wdata, host_rdata;
  logic [4:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_result;
  logic       done;
`ifdef ALU_ISSUE_FLAGS_EN
  logic       flag_z, flag_n;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct {
    instr_t     ins;
    logic [7:0] a, b, res;
    logic [4:0] aop;
    logic       z, n;
  } vec_t;

  typedef struct {
    logic [2:0] rd;
    logic [7:0] val;
    logic       z, n;
  } exp_t;

  vec_t vt[13];
  exp_t sb[$];

  alu_issue_if ifc ();

  alu_issue_ctrl #(.NREGS(8), .DW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_if   (ifc.slave),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .done       (done)
`ifdef ALU_ISSUE_FLAGS_EN
    ,
    .flag_z     (flag_z),
    .flag_n     (flag_n)
`endif
  );

  // Reference ALU; NOT is logical (0x00 -> 0x01, else 0x00).
  always_comb begin
    alu_result = 8'hFF;
    case (alu_op)
      5'b00000: alu_result = alu_a & alu_b;
      5'b00001: alu_result = alu_a | alu_b;
      5'b00010: alu_result = (alu_a == 8'h00) ? 8'h01 : 8'h00;
      5'b00011: alu_result = alu_a ^ alu_b;
      5'b00100: alu_result = alu_a + alu_b;
      5'b00101: alu_result = alu_a - alu_b;
      5'b10000: alu_result = (alu_b >= 8'd8) ? 8'h00 : (alu_a << alu_b[2:0]);
      5'b10001: alu_result = (alu_b >= 8'd8) ? 8'h00 : (alu_a >> alu_b[2:0]);
      default:  alu_result = 8'hFF;
    endcase
  end

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, rd, rs, input logic [7:0] a, b, res,
                              input logic [4:0] aop, input logic z, n);
    vec_t v;
    v.ins = '{op: op, rd: rd, rs: rs};
    v.a = a; v.b = b; v.res = res; v.aop = aop; v.z = z; v.n = n;
    return v;
  endfunction

  task automatic hwrite(input logic [2:0] addr, input logic [7:0] data);
    @(negedge clk);
    host_we = 1'b1; host_addr = addr; host_wdata = data;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic issue(input instr_t ins);
    bit acc = 1'b0;
    @(negedge clk);
    ifc.instr_valid = 1'b1;
    ifc.instr = ins;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (ifc.instr_ready) begin
        @(posedge clk);
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1 ifc.instr_valid = 1'b0;
    chk("accept", 32'(acc), 32'd1);
  endtask

  // Walks DECODE/EXEC/WB/IDLE after an accept; optional host write during WB.
  task automatic complete(input logic [4:0] eaop, input logic [7:0] ea, eb,
                          input bit inj, input logic [2:0] iaddr, input logic [7:0] idata);
    exp_t e;
    bit   got = 1'b0;
    @(negedge clk);
    chk("done_decode", 32'(done), 32'd0);
    chk("ready_decode", 32'(ifc.instr_ready), 32'd0);
    @(negedge clk);
    chk("done_exec", 32'(done), 32'd0);
    chk("alu_op", 32'(alu_op), 32'(eaop));
    chk("alu_a", 32'(alu_a), 32'(ea));
    chk("alu_b", 32'(alu_b), 32'(eb));
    @(negedge clk);
    chk("done_wb", 32'(done), 32'd1);
    if (done && sb.size() > 0) begin
      e = sb.pop_front();
      got = 1'b1;
    end
    if (inj) begin
      host_we = 1'b1; host_addr = iaddr; host_wdata = idata;
    end
    @(negedge clk);
    host_we = 1'b0;
    chk("done_idle", 32'(done), 32'd0);
    chk("alu_a_hold", 32'(alu_a), 32'(ea));
    chk("sb_pop", 32'(got), 32'd1);
    if (got) begin
      host_addr = e.rd;
      #1 chk("wb_value", 32'(host_rdata), 32'(e.val));
`ifdef ALU_ISSUE_FLAGS_EN
      chk("flag_z", 32'(flag_z), 32'(e.z));
      chk("flag_n", 32'(flag_n), 32'(e.n));
`endif
    end
  endtask

  task automatic run_vec(input vec_t v);
    hwrite(v.ins.rs, v.b);
    hwrite(v.ins.rd, v.a);
    sb.push_back('{rd: v.ins.rd, val: v.res, z: v.z, n: v.n});
    issue(v.ins);
    complete(v.aop, v.a, v.b, 1'b0, 3'd0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int unsigned acc_cyc[$];
    vec_t        v;

    //         op      rd    rs    a      b      res    aop       z     n
    vt[0]  = mk(3'd4, 3'd1, 3'd2, 8'h05, 8'h03, 8'h08, 5'b00100, 1'b0, 1'b0);
    vt[1]  = mk(3'd4, 3'd3, 3'd4, 8'hFF, 8'h01, 8'h00, 5'b00100, 1'b1, 1'b0);
    vt[2]  = mk(3'd0, 3'd1, 3'd2, 8'hF0, 8'h3C, 8'h30, 5'b00000, 1'b0, 1'b0);
    vt[3]  = mk(3'd1, 3'd1, 3'd2, 8'hF0, 8'h0F, 8'hFF, 5'b00001, 1'b0, 1'b1);
    vt[4]  = mk(3'd3, 3'd6, 3'd7, 8'hAA, 8'hFF, 8'h55, 5'b00011, 1'b0, 1'b0);
    vt[5]  = mk(3'd5, 3'd2, 3'd1, 8'h00, 8'h01, 8'hFF, 5'b00101, 1'b0, 1'b1);
    vt[6]  = mk(3'd6, 3'd5, 3'd6, 8'h01, 8'h07, 8'h80, 5'b10000, 1'b0, 1'b1);
    vt[7]  = mk(3'd7, 3'd5, 3'd6, 8'h80, 8'h07, 8'h01, 5'b10001, 1'b0, 1'b0);
    vt[8]  = mk(3'd6, 3'd1, 3'd2, 8'h01, 8'h08, 8'h00, 5'b10000, 1'b1, 1'b0);
    vt[9]  = mk(3'd7, 3'd1, 3'd2, 8'hFF, 8'h09, 8'h00, 5'b10001, 1'b1, 1'b0);
    vt[10] = mk(3'd2, 3'd3, 3'd4, 8'h00, 8'h55, 8'h01, 5'b00010, 1'b0, 1'b0);
    vt[11] = mk(3'd4, 3'd7, 3'd7, 8'h40, 8'h40, 8'h80, 5'b00100, 1'b0, 1'b1);
    vt[12] = mk(3'd5, 3'd0, 3'd0, 8'h5A, 8'h5A, 8'h00, 5'b00101, 1'b1, 1'b0);

    rst_n = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    ifc.instr_valid = 1'b0; ifc.instr = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(ifc.instr_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
`ifdef ALU_ISSUE_FLAGS_EN
    chk("rst_flag_z", 32'(flag_z), 32'd0);
    chk("rst_flag_n", 32'(flag_n), 32'd0);
`endif
    for (int r = 0; r < 8; r++) begin
      host_addr = 3'(r);
      #1 chk("rst_reg", 32'(host_rdata), 32'd0);
    end

    foreach (vt[i]) run_vec(vt[i]);

    // Host write in IDLE holds off a pending instruction.
    hwrite(3'd0, 8'h02);
    hwrite(3'd1, 8'h03);
    @(negedge clk);
    host_we = 1'b1; host_addr = 3'd3; host_wdata = 8'h11;
    ifc.instr_valid = 1'b1; ifc.instr = '{op: 3'd4, rd: 3'd0, rs: 3'd1};
    for (int i = 0; i < 3; i++) begin
      #1 chk("ready_host_block", 32'(ifc.instr_ready), 32'd0);
      @(negedge clk);
    end
    host_we = 1'b0; ifc.instr_valid = 1'b0;
    #1 chk("no_accept_under_host", 32'(ifc.instr_ready), 32'd1);
    host_addr = 3'd3;
    #1 chk("host_write_r3", 32'(host_rdata), 32'h11);
    sb.push_back('{rd: 3'd0, val: 8'h05, z: 1'b0, n: 1'b0});
    issue('{op: 3'd4, rd: 3'd0, rs: 3'd1});
    complete(5'b00100, 8'h02, 8'h03, 1'b0, 3'd0, 8'h00);

    // Writeback beats a same-address host write in WB; other addresses still written.
    hwrite(3'd2, 8'h03);
    hwrite(3'd1, 8'h05);
    sb.push_back('{rd: 3'd1, val: 8'h08, z: 1'b0, n: 1'b0});
    issue('{op: 3'd4, rd: 3'd1, rs: 3'd2});
    complete(5'b00100, 8'h05, 8'h03, 1'b1, 3'd1, 8'hEE);
    hwrite(3'd1, 8'h05);
    sb.push_back('{rd: 3'd1, val: 8'h08, z: 1'b0, n: 1'b0});
    issue('{op: 3'd4, rd: 3'd1, rs: 3'd2});
    complete(5'b00100, 8'h05, 8'h03, 1'b1, 3'd4, 8'hEE);
    host_addr = 3'd4;
    #1 chk("wb_host_other_addr", 32'(host_rdata), 32'hEE);

    // Back-to-back: valid held high, accepts must be 4 cycles apart.
    hwrite(3'd1, 8'h01);
    hwrite(3'd2, 8'h01);
    @(negedge clk);
    ifc.instr_valid = 1'b1; ifc.instr = '{op: 3'd4, rd: 3'd1, rs: 3'd2};
    for (int c = 0; c < 12; c++) begin
      #1;
      if (ifc.instr_ready) acc_cyc.push_back(c);
      @(negedge clk);
    end
    ifc.instr_valid = 1'b0;
    chk("b2b_count", acc_cyc.size(), 32'd3);
    if (acc_cyc.size() == 3) begin
      chk("b2b_gap0", acc_cyc[1] - acc_cyc[0], 32'd4);
      chk("b2b_gap1", acc_cyc[2] - acc_cyc[1], 32'd4);
    end
    host_addr = 3'd1;
    #1 chk("b2b_r1", 32'(host_rdata), 32'h04);

    // Reset during EXEC aborts without a done pulse.
    hwrite(3'd2, 8'h10);
    hwrite(3'd3, 8'h20);
    issue('{op: 3'd4, rd: 3'd2, rs: 3'd3});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("rst_exec_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("rst_hold_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", 32'(ifc.instr_ready), 32'd1);
    chk("rel_alu_a", 32'(alu_a), 32'd0);
    chk("rel_alu_op", 32'(alu_op), 32'd0);
    for (int r = 0; r < 8; r++) begin
      host_addr = 3'(r);
      #1 chk("rel_reg", 32'(host_rdata), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rel_no_done", 32'(done), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
